// File: rtl/jtdsp16_sio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtdsp16_sio_pkg
// Description : Shared definitions for the jtdsp16 serial input receiver.
//               Holds the FSM state encoding, the word-length codes, the bit
//               counter width and the bit-placement helper.
// Revision    : 1.0 - initial release
// ============================================================================
package jtdsp16_sio_pkg;

  // Bit counter width: must hold the value 16
  localparam int CNT_W = 5;

  // Word-length codes as seen on the ilen pin
  localparam logic LEN16 = 1'b0;
  localparam logic LEN8  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } sio_state_t;

  // Number of bits in a frame for the given word-length code
  function automatic logic [CNT_W-1:0] frame_bits(input logic len);
    return (len == LEN8) ? 5'd8 : 5'd16;
  endfunction

  // Insert one received bit into the partial word.
  // MSB-first shifts left with the new bit at bit 0. LSB-first shifts right
  // with the new bit at the top of the active field (bit 7 or bit 15), so an
  // 8-bit word always ends up in [7:0] with the upper byte zero.
  function automatic logic [15:0] shift_in(input logic [15:0] word,
                                           input logic        din,
                                           input logic        len,
                                           input logic        msb_first);
    logic [15:0] w_next;
    w_next = word;
    if (msb_first)
      w_next = {word[14:0], din};
    else if (len == LEN8)
      w_next = {8'h00, din, word[7:1]};
    else
      w_next = {din, word[15:1]};
    return w_next;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtdsp16_sio_sync.sv
`default_nettype none
// ============================================================================
// Module      : jtdsp16_sio_sync
// Description : SYNC_STAGES-deep synchronizer for ick, ild and sdi plus an
//               ick rising-edge detector. ild/sdi are tapped at the same
//               depth as the synchronized ick so they stay aligned with it.
// Ports       : clk, rst, clk_en     - core clock, sync reset, clock enable
//               ick, ild, sdi        - asynchronous pin inputs
//               ick_rise             - one-cycle pulse on a synced ick rise
//               ild_s, sdi_s         - synced ild/sdi aligned to ick_rise
// Revision    : 1.0 - initial release
// ============================================================================
module jtdsp16_sio_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic ick,
  input  logic ild,
  input  logic sdi,
  output logic ick_rise,
  output logic ild_s,
  output logic sdi_s
);

  logic [SYNC_STAGES-1:0] r_ick_sync;
  logic [SYNC_STAGES-1:0] r_ild_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_ick_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ick_sync <= '0;
      r_ild_sync <= '0;
      r_sdi_sync <= '0;
      r_ick_prev <= 1'b0;
    end else if (clk_en) begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        r_ick_sync[i] <= r_ick_sync[i-1];
        r_ild_sync[i] <= r_ild_sync[i-1];
        r_sdi_sync[i] <= r_sdi_sync[i-1];
      end
      r_ick_sync[0] <= ick;
      r_ild_sync[0] <= ild;
      r_sdi_sync[0] <= sdi;
      r_ick_prev    <= r_ick_sync[SYNC_STAGES-1];
    end
  end

  assign ick_rise = r_ick_sync[SYNC_STAGES-1] & ~r_ick_prev;
  assign ild_s    = r_ild_sync[SYNC_STAGES-1];
  assign sdi_s    = r_sdi_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/jtdsp16_sio_rx.sv
`default_nettype none
// ============================================================================
// Module      : jtdsp16_sio_rx
// Description : jtdsp16 serial input receiver. Assembles 8/16-bit words from
//               ick/ild/sdi, loads them into sdx and raises ibf, ovf and ise.
// Ports       : clk, rst, clk_en - core clock, sync reset, clock enable
//               ick, ild, sdi    - external bit clock, frame sync, data
//               ilen, msb_first  - word length (1 = 8 bit), bit order
//               rd               - core read strobe, clears ibf/ovf
//               sdx              - received word
//               ibf, ovf, ise    - buffer full, sticky overrun, load pulse
// Revision    : 1.0 - initial release
// ============================================================================
module jtdsp16_sio_rx
  import jtdsp16_sio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        ick,
  input  logic        ild,
  input  logic        sdi,
  input  logic        ilen,
  input  logic        msb_first,
  input  logic        rd,
  output logic [15:0] sdx,
  output logic        ibf,
  output logic        ovf,
  output logic        ise
);

  logic             w_rise;
  logic             w_ild;
  logic             w_sdi;
  logic [CNT_W-1:0] w_cnt_nx;

  sio_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_word;
  logic             r_len;
  logic             r_msb;
  logic [15:0]      r_sdx;
  logic             r_ibf;
  logic             r_ovf;
  logic             r_ise;

  jtdsp16_sio_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .ick      (ick),
    .ild      (ild),
    .sdi      (sdi),
    .ick_rise (w_rise),
    .ild_s    (w_ild),
    .sdi_s    (w_sdi)
  );

  assign w_cnt_nx = r_cnt + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_len   <= LEN16;
      r_msb   <= 1'b0;
      r_sdx   <= '0;
      r_ibf   <= 1'b0;
      r_ovf   <= 1'b0;
      r_ise   <= 1'b0;
    end else if (clk_en) begin
      r_ise <= 1'b0;
      // Read clears the flags; a coincident load below overrides ibf
      if (rd) begin
        r_ibf <= 1'b0;
        r_ovf <= 1'b0;
      end
      case (r_state)
        ST_IDLE, ST_SHIFT: begin
          if (w_rise) begin
            if (w_ild) begin
              // Frame start (or restart): drop any partial word and
              // re-latch the frame format from the pins
              r_word  <= shift_in(16'h0000, w_sdi, ilen, msb_first);
              r_cnt   <= 5'd1;
              r_len   <= ilen;
              r_msb   <= msb_first;
              r_state <= ST_SHIFT;
            end else if (r_state == ST_SHIFT) begin
              r_word <= shift_in(r_word, w_sdi, r_len, r_msb);
              r_cnt  <= w_cnt_nx;
              if (w_cnt_nx == frame_bits(r_len))
                r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          r_sdx   <= r_word;
          r_ibf   <= 1'b1;
          r_ise   <= 1'b1;
          if (r_ibf && !rd)
            r_ovf <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sdx = r_sdx;
  assign ibf = r_ibf;
  assign ovf = r_ovf;
  assign ise = r_ise;

endmodule
`default_nettype wire

// File: tb/tb_jtdsp16_sio_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtdsp16_sio_rx
// Description : Self-checking bench for jtdsp16_sio_rx. Table of directed
//               frames plus hand-written sequences for latency, overrun,
//               read/load collision, resync, reset and clock-enable freeze.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtdsp16_sio_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        ick = 1'b0;
  logic        ild = 1'b0;
  logic        sdi = 1'b0;
  logic        ilen = 1'b0;
  logic        msb_first = 1'b1;
  logic        rd = 1'b0;
  logic [15:0] sdx;
  logic        ibf;
  logic        ovf;
  logic        ise;

  int checks = 0;
  int failures = 0;
  int ise_cnt = 0;

  typedef struct {
    logic [15:0] data;
    logic        len8;
    logic        msb;
    logic        rd_before;
    logic [15:0] exp_sdx;
    logic        exp_ibf;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[6];

  jtdsp16_sio_rx #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .ick       (ick),
    .ild       (ild),
    .sdi       (sdi),
    .ilen      (ilen),
    .msb_first (msb_first),
    .rd        (rd),
    .sdx       (sdx),
    .ibf       (ibf),
    .ovf       (ovf),
    .ise       (ise)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ise) ise_cnt <= ise_cnt + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Send sequence positions first..first+cnt-1 of a frame; ild marks position 0.
  // Each bit: ick low 4 clk with data set up, then ick high 4 clk.
  task automatic send_bits(input logic [15:0] word, input logic len8, input logic msb,
                           input int first, input int cnt);
    int n;
    n = len8 ? 8 : 16;
    for (int k = first; k < first + cnt; k++) begin
      @(negedge clk);
      ilen      = len8;
      msb_first = msb;
      ick       = 1'b0;
      ild       = (k == 0);
      sdi       = msb ? word[n-1-k] : word[k];
      repeat (4) @(negedge clk);
      ick = 1'b1;
      repeat (4) @(negedge clk);
      ick = 1'b0;
    end
    ild = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("rd_clears_ibf", {15'd0, ibf}, 16'd0);
    check("rd_clears_ovf", {15'd0, ovf}, 16'd0);
  endtask

  initial begin
    int n0;
    vecs[0] = '{16'h00A5, 1'b1, 1'b0, 1'b1, 16'h00A5, 1'b1, 1'b0};
    vecs[1] = '{16'h0081, 1'b1, 1'b1, 1'b1, 16'h0081, 1'b1, 1'b0};
    vecs[2] = '{16'h1357, 1'b0, 1'b0, 1'b1, 16'h1357, 1'b1, 1'b0};
    vecs[3] = '{16'h1234, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0};
    vecs[4] = '{16'hBEEF, 1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b1};
    vecs[5] = '{16'h00C3, 1'b1, 1'b1, 1'b1, 16'h00C3, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_sdx", sdx, 16'h0000);
    check("reset_ibf", {15'd0, ibf}, 16'd0);
    check("reset_ovf", {15'd0, ovf}, 16'd0);
    check("reset_ise", {15'd0, ise}, 16'd0);

    // 0xCAFE MSB-first with latency measured from the last ick rise
    send_bits(16'hCAFE, 1'b0, 1'b1, 0, 15);
    @(negedge clk);
    sdi = 1'b0;
    repeat (4) @(negedge clk);
    ick = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("cafe_ibf_edge%0d", e), {15'd0, ibf}, {15'd0, e >= 4});
      check($sformatf("cafe_ise_edge%0d", e), {15'd0, ise}, {15'd0, e == 4});
    end
    check("cafe_sdx", sdx, 16'hCAFE);
    check("cafe_ovf", {15'd0, ovf}, 16'd0);
    repeat (3) @(negedge clk);
    ick = 1'b0;
    settle();

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].rd_before) pulse_rd();
      send_bits(vecs[i].data, vecs[i].len8, vecs[i].msb, 0, vecs[i].len8 ? 8 : 16);
      settle();
      check($sformatf("vec%0d_sdx", i), sdx, vecs[i].exp_sdx);
      check($sformatf("vec%0d_ibf", i), {15'd0, ibf}, {15'd0, vecs[i].exp_ibf});
      check($sformatf("vec%0d_ovf", i), {15'd0, ovf}, {15'd0, vecs[i].exp_ovf});
    end
    pulse_rd();

    // rd coincident with LOAD while ibf=1 and ovf=1
    send_bits(16'h1111, 1'b0, 1'b1, 0, 16);
    settle();
    send_bits(16'h2222, 1'b0, 1'b1, 0, 16);
    settle();
    check("pre_coll_ovf", {15'd0, ovf}, 16'd1);
    send_bits(16'hDEAD, 1'b0, 1'b1, 0, 15);
    @(negedge clk);
    sdi = 1'b1;
    repeat (4) @(negedge clk);
    ick = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("coll_sdx", sdx, 16'hDEAD);
    check("coll_ibf", {15'd0, ibf}, 16'd1);
    check("coll_ovf", {15'd0, ovf}, 16'd0);
    repeat (2) @(negedge clk);
    ick = 1'b0;
    settle();

    // Resync: 6 garbage bits then a fresh frame; exactly one load
    pulse_rd();
    n0 = ise_cnt;
    send_bits(16'hFFFF, 1'b0, 1'b1, 0, 6);
    send_bits(16'h5555, 1'b0, 1'b1, 0, 16);
    settle();
    check("resync_sdx", sdx, 16'h5555);
    check("resync_loads", 16'(ise_cnt - n0), 16'd1);

    // Reset after 9 bits of a frame
    send_bits(16'hAAAA, 1'b0, 1'b1, 0, 9);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_sdx", sdx, 16'h0000);
    check("midrst_ibf", {15'd0, ibf}, 16'd0);
    check("midrst_ovf", {15'd0, ovf}, 16'd0);
    check("midrst_ise", {15'd0, ise}, 16'd0);
    send_bits(16'h0F0F, 1'b0, 1'b1, 0, 16);
    settle();
    check("after_rst_sdx", sdx, 16'h0F0F);
    check("after_rst_ibf", {15'd0, ibf}, 16'd1);

    // clk_en held low mid-frame
    pulse_rd();
    n0 = ise_cnt;
    send_bits(16'h3C3C, 1'b0, 1'b1, 0, 8);
    @(negedge clk);
    clk_en = 1'b0;
    repeat (20) @(negedge clk);
    check("freeze_ibf", {15'd0, ibf}, 16'd0);
    clk_en = 1'b1;
    send_bits(16'h3C3C, 1'b0, 1'b1, 8, 8);
    settle();
    check("freeze_sdx", sdx, 16'h3C3C);
    check("freeze_ibf_after", {15'd0, ibf}, 16'd1);
    check("freeze_loads", 16'(ise_cnt - n0), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtdsp16_sio_rx.md
Name: jtdsp16_sio_rx

Overview:
- Serial input receiver for the jtdsp16 core. It is the input-direction counterpart of the serial output port (sdo/ock/sadd).
- Samples external ick/ild/sdi, assembles 8- or 16-bit words, and loads them into the sdx input register.
- Flags input-buffer-full (ibf) and overrun (ovf) to the core.
- Sits beside the serial output unit inside jtdsp16. Driven from the core clock domain, gated by clk_en.

Parameters:
- SYNC_STAGES, 2, depth of the ick/ild/sdi input synchronizers; legal range 1..3.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- clk_en  input  1  clock enable; all state advances only when high
- ick  input  1  external serial input bit clock, asynchronous to clk
- ild  input  1  external frame-sync strobe; high marks the first bit of a word
- sdi  input  1  external serial data
- ilen  input  1  word length: 0 = 16 bits, 1 = 8 bits
- msb_first  input  1  1 = MSB received first, 0 = LSB first
- rd  input  1  one-cycle pulse: core reads sdx; clears ibf and ovf
- sdx  output  16  received word
- ibf  output  1  input buffer full
- ovf  output  1  sticky overrun flag
- ise  output  1  one-cycle pulse on each word load (interrupt source)

Behaviour:
- Reset: sdx=0, ibf=0, ovf=0, ise=0, FSM=IDLE, bit counter=0, shift register=0, synchronizer stages=0. Reset mid-frame discards the partial word.
- Synchronization and edge detection:
  - ick, ild and sdi pass through SYNC_STAGES flops each.
  - An ick rising edge is detected as synced_ick & ~prev_synced_ick, with one extra flop.
  - ild and sdi are used at the same delay as synced_ick, so they stay aligned.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE:
  - On an ick rise with ild=1: capture sdi as bit 0 and latch ilen and msb_first for this frame.
  - Set count=1, go to SHIFT.
  - An ick rise with ild=0 is ignored.
- SHIFT:
  - Each ick rise captures one bit and increments count.
  - When count reaches N (N=16, or 8 if the latched ilen=1), go to LOAD.
  - An ick rise with ild=1 in SHIFT restarts the frame: the partial word is dropped, that bit becomes bit 0, and ilen/msb_first are re-latched.
- Bit placement:
  - msb_first=1: shift left, new bit enters bit 0.
  - msb_first=0: shift right, new bit enters bit N-1.
  - 8-bit words land in sdx[7:0] with sdx[15:8]=0.
- LOAD (one clk_en cycle):
  - sdx<=word, ibf<=1, ise=1 for this cycle, then go to IDLE.
  - An ick rise arriving in the same cycle as LOAD is evaluated by IDLE rules on the next cycle only if still detected. Senders must space frames by at least one ick period.
- Overrun: if ibf=1 at LOAD and rd is not asserted that cycle, ovf<=1 and sdx is overwritten with the new word.
- rd, with no LOAD in the same cycle: ibf<=0 and ovf<=0 on the next enabled edge.
- rd and LOAD in the same cycle: the load wins. ibf stays 1, ovf<=0, sdx holds the new word.
- Latency: ibf rises SYNC_STAGES+2 enabled clk edges after the last-bit ick rise at the pin (4 with the default).
- clk_en=0 freezes all registers, including the synchronizers. ise is a pulse 1 enabled cycle wide.

Decomposition:
- Shared package jtdsp16_sio_pkg holds:
  - FSM state encoding (IDLE/SHIFT/LOAD).
  - Word-length constants (LEN16=0, LEN8=1).
  - Bit-count width (5 bits).
- One sub-module: jtdsp16_sio_sync. It is an N-stage synchronizer plus rising-edge detector, instantiated for ick with aligned ild/sdi taps.

Test Plan:
- 16-bit MSB-first frame 0xCAFE with ild high on the first bit, ick period 8 clk. Required: sdx=0xCAFE, ibf=1 and ise pulse 4 cycles after the last ick rise; ovf=0.
- 8-bit LSB-first frame 0xA5 (ilen=1, msb_first=0). Required: sdx=0x00A5 and ibf=1. Then pulse rd: ibf=0 the next cycle.
- Overrun: send 0x1234, no rd, then send 0xBEEF. Required: sdx=0xBEEF, ibf=1, ovf=1. A later rd pulse clears both flags.
- rd coincident with the LOAD cycle of 0xDEAD while ibf=1. Required: ibf stays 1, ovf=0, sdx=0xDEAD.
- Resync: 6 bits of garbage, then ild re-asserted and a full 0x5555 sent. Required: sdx=0x5555 with no spurious load.
- Edge cases:
  - rst asserted after 9 bits of a frame: all outputs read 0, and the next complete frame 0x0F0F loads correctly.
  - clk_en held low for 20 cycles mid-frame with ick stopped: state is preserved, and the word completes correctly afterwards.
